// File: rtl/hydra_pkg.sv
// Shared definitions for the strand scheduler: FSM encoding and default sizing.
package hydra_pkg;

   localparam int unsigned DEF_NUM_STRANDS  = 4;
   localparam int unsigned DEF_PERIOD_WIDTH = 24;
   localparam int unsigned DEF_COUNT_WIDTH  = 16;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_TICK = 2'd1,
      START     = 2'd2,
      RUN       = 2'd3
   } sched_state_e;

endpackage

// File: rtl/strand_frame_timer.sv
// Frame period counter; tick is high for one cycle every max(period,2) cycles while run is high.
module strand_frame_timer
   import hydra_pkg::*;
#(
   parameter int unsigned PERIOD_WIDTH = DEF_PERIOD_WIDTH
)(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    run,
   input  logic [PERIOD_WIDTH-1:0] period,
   output logic                    tick
);

   logic [PERIOD_WIDTH-1:0] cnt_q, cnt_d;
   logic [PERIOD_WIDTH-1:0] per_q, per_d;
   logic [PERIOD_WIDTH-1:0] lim_q, lim_d;
   logic                    tick_q, tick_d;

   // Periods below 2 are clamped so a frame always has a START and a RUN cycle.
   always_comb begin
      cnt_d  = '0;
      per_d  = per_q;
      lim_q  = (per_q < PERIOD_WIDTH'(2)) ? PERIOD_WIDTH'(2) : per_q;
      if (!run || tick_q) begin
         per_d = period;
      end else begin
         cnt_d = cnt_q + PERIOD_WIDTH'(1);
      end
      lim_d  = (per_d < PERIOD_WIDTH'(2)) ? PERIOD_WIDTH'(2) : per_d;
      tick_d = run && (cnt_d == lim_d - PERIOD_WIDTH'(1));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         per_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         per_q  <= per_d;
         tick_q <= tick_d;
      end
   end

   assign tick = tick_q;

endmodule

// File: rtl/strand_scheduler.sv
// Periodic frame sequencer: launches idle enabled strands on each period tick and tracks completion.
module strand_scheduler
   import hydra_pkg::*;
#(
   parameter int unsigned NUM_STRANDS  = DEF_NUM_STRANDS,
   parameter int unsigned PERIOD_WIDTH = DEF_PERIOD_WIDTH,
   parameter int unsigned COUNT_WIDTH  = DEF_COUNT_WIDTH
)(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    enable,
   input  logic [PERIOD_WIDTH-1:0] frame_period,
   input  logic [NUM_STRANDS-1:0]  strand_enable,
   input  logic [NUM_STRANDS-1:0]  strand_busy,
   input  logic [NUM_STRANDS-1:0]  strand_done,
   output logic [NUM_STRANDS-1:0]  start_frame,
   output logic                    frame_active,
   output logic                    frame_done,
   output logic                    overrun,
   output logic [COUNT_WIDTH-1:0]  frame_count,
   output logic [COUNT_WIDTH-1:0]  overrun_count
);

   sched_state_e           state_q, state_d;
   logic [NUM_STRANDS-1:0] pending_q, pending_d;
   logic [NUM_STRANDS-1:0] start_q, start_d;
   logic [NUM_STRANDS-1:0] launch;
   logic                   skip;
   logic                   active_q;
   logic                   done_q, done_d;
   logic                   ovr_q, ovr_d;
   logic [COUNT_WIDTH-1:0] fcnt_q, ocnt_q;
   logic                   tick;

   strand_frame_timer #(
      .PERIOD_WIDTH (PERIOD_WIDTH)
   ) u_timer (
      .clk    (clk),
      .rst    (rst),
      .run    (state_q != IDLE),
      .period (frame_period),
      .tick   (tick)
   );

   assign launch = strand_enable & ~strand_busy;
   assign skip   = |(strand_enable & strand_busy);

   // Launch decisions are registered so start_frame and pending appear together in START.
   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      start_d   = '0;
      done_d    = 1'b0;
      ovr_d     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (enable) state_d = WAIT_TICK;
         end
         WAIT_TICK: begin
            if (!enable) begin
               state_d = IDLE;
            end else if (tick) begin
               state_d   = START;
               start_d   = launch;
               pending_d = launch;
               ovr_d     = skip;
            end
         end
         START: begin
            state_d = RUN;
            if (pending_q == '0) done_d = 1'b1;
         end
         RUN: begin
            pending_d = pending_q & ~strand_done;
            if (pending_q != '0 && pending_d == '0) done_d = 1'b1;
            // A finished frame accepts a coincident tick as a normal launch.
            if (pending_d == '0) begin
               if (!enable) begin
                  state_d = IDLE;
               end else if (tick) begin
                  state_d   = START;
                  start_d   = launch;
                  pending_d = launch;
                  ovr_d     = skip;
               end else begin
                  state_d = WAIT_TICK;
               end
            end else if (tick) begin
               ovr_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         pending_q <= '0;
         start_q   <= '0;
         active_q  <= 1'b0;
         done_q    <= 1'b0;
         ovr_q     <= 1'b0;
         fcnt_q    <= '0;
         ocnt_q    <= '0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         start_q   <= start_d;
         active_q  <= (state_d == START) || (state_d == RUN);
         done_q    <= done_d;
         ovr_q     <= ovr_d;
         if (done_d) fcnt_q <= fcnt_q + COUNT_WIDTH'(1);
         if (ovr_d)  ocnt_q <= ocnt_q + COUNT_WIDTH'(1);
      end
   end

   assign start_frame   = start_q;
   assign frame_active  = active_q;
   assign frame_done    = done_q;
   assign overrun       = ovr_q;
   assign frame_count   = fcnt_q;
   assign overrun_count = ocnt_q;

endmodule

// File: tb/tb_strand_scheduler.sv
// Directed self-checking bench for strand_scheduler with hand-computed cycle expectations.
module tb_strand_scheduler;

   logic        clk;
   logic        rst;
   logic        enable;
   logic [23:0] frame_period;
   logic [3:0]  strand_enable;
   logic [3:0]  strand_busy;
   logic [3:0]  strand_done;
   logic [3:0]  start_frame;
   logic        frame_active;
   logic        frame_done;
   logic        overrun;
   logic [15:0] frame_count;
   logic [15:0] overrun_count;

   int n_cmp = 0;
   int n_err = 0;

   strand_scheduler #(
      .NUM_STRANDS  (4),
      .PERIOD_WIDTH (24),
      .COUNT_WIDTH  (16)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .enable        (enable),
      .frame_period  (frame_period),
      .strand_enable (strand_enable),
      .strand_busy   (strand_busy),
      .strand_done   (strand_done),
      .start_frame   (start_frame),
      .frame_active  (frame_active),
      .frame_done    (frame_done),
      .overrun       (overrun),
      .frame_count   (frame_count),
      .overrun_count (overrun_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_edges(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst         = 1'b1;
      enable      = 1'b0;
      strand_busy = '0;
      strand_done = '0;
      wait_edges(2);
      rst = 1'b0;
   endtask

   // Raises enable and returns just after the edge that enters START.
   task automatic start_run(input int p);
      frame_period = 24'(p);
      enable       = 1'b1;
      wait_edges(p + 1);
   endtask

   initial begin
      int starts;
      rst           = 1'b1;
      enable        = 1'b0;
      frame_period  = 24'd1000;
      strand_enable = 4'b1111;
      strand_busy   = '0;
      strand_done   = '0;
      #1;
      check_eq("rst_start",   32'(start_frame), 32'h0);
      check_eq("rst_active",  32'(frame_active), 32'h0);
      check_eq("rst_counts",  32'({frame_count, overrun_count}), 32'h0);
      check_eq("rst_pulses",  32'({frame_done, overrun}), 32'h0);
      wait_edges(2);
      rst = 1'b0;

      // Single frame, period 1000, all dones 300 cycles after start.
      enable = 1'b1;
      wait_edges(1000);
      check_eq("single_pre_start", 32'(start_frame), 32'h0);
      wait_edges(1);
      check_eq("single_start", 32'(start_frame), 32'hf);
      check_eq("single_active", 32'(frame_active), 32'h1);
      wait_edges(1);
      check_eq("single_start_pulse", 32'(start_frame), 32'h0);
      wait_edges(299);
      strand_done = 4'b1111;
      check_eq("single_fd_early", 32'(frame_done), 32'h0);
      wait_edges(1);
      strand_done = '0;
      check_eq("single_fd", 32'(frame_done), 32'h1);
      check_eq("single_count", 32'(frame_count), 32'h1);
      check_eq("single_inactive", 32'(frame_active), 32'h0);
      wait_edges(1);
      check_eq("single_fd_pulse", 32'(frame_done), 32'h0);

      // Staggered and simultaneous dones.
      do_reset();
      strand_enable = 4'b1111;
      start_run(20);
      check_eq("stag_start", 32'(start_frame), 32'hf);
      wait_edges(2);
      strand_done = 4'b0101;
      wait_edges(1);
      strand_done = '0;
      check_eq("stag_fd_after02", 32'(frame_done), 32'h0);
      wait_edges(1);
      strand_done = 4'b0011;
      wait_edges(1);
      strand_done = '0;
      check_eq("stag_fd_after1", 32'(frame_done), 32'h0);
      check_eq("stag_active", 32'(frame_active), 32'h1);
      wait_edges(2);
      strand_done = 4'b1000;
      wait_edges(1);
      strand_done = '0;
      check_eq("stag_fd", 32'(frame_done), 32'h1);
      check_eq("stag_count", 32'(frame_count), 32'h1);
      check_eq("stag_no_ovr", 32'(overrun_count), 32'h0);

      // Overrun: strand 1 never finishes.
      do_reset();
      start_run(200);
      check_eq("ovr_start", 32'(start_frame), 32'hf);
      wait_edges(2);
      strand_done = 4'b1101;
      wait_edges(1);
      strand_done = '0;
      wait_edges(196);
      check_eq("ovr_pre", 32'(overrun), 32'h0);
      wait_edges(1);
      check_eq("ovr_pulse", 32'(overrun), 32'h1);
      check_eq("ovr_count", 32'(overrun_count), 32'h1);
      check_eq("ovr_no_start", 32'(start_frame), 32'h0);
      check_eq("ovr_active", 32'(frame_active), 32'h1);
      wait_edges(1);
      check_eq("ovr_pulse_end", 32'(overrun), 32'h0);

      // Busy strand skipped at launch.
      do_reset();
      strand_busy = 4'b0100;
      start_run(50);
      strand_busy = '0;
      check_eq("busy_start", 32'(start_frame), 32'hb);
      check_eq("busy_ovr", 32'(overrun), 32'h1);
      check_eq("busy_ovr_count", 32'(overrun_count), 32'h1);
      wait_edges(1);
      check_eq("busy_ovr_once", 32'(overrun), 32'h0);
      wait_edges(1);
      strand_done = 4'b1011;
      wait_edges(1);
      strand_done = '0;
      check_eq("busy_fd", 32'(frame_done), 32'h1);
      check_eq("busy_count", 32'(frame_count), 32'h1);
      check_eq("busy_ovr_total", 32'(overrun_count), 32'h1);

      // Period 0 clamps to 2; empty launch set completes 2 cycles after each tick.
      do_reset();
      strand_enable = 4'b0000;
      frame_period  = 24'd0;
      enable        = 1'b1;
      wait_edges(3);
      check_eq("edge_fd_early", 32'(frame_done), 32'h0);
      check_eq("edge_active", 32'(frame_active), 32'h1);
      wait_edges(1);
      check_eq("edge_fd1", 32'(frame_done), 32'h1);
      check_eq("edge_count1", 32'(frame_count), 32'h1);
      wait_edges(1);
      check_eq("edge_fd_gap", 32'(frame_done), 32'h0);
      wait_edges(1);
      check_eq("edge_count2", 32'(frame_count), 32'h2);
      wait_edges(10);
      check_eq("edge_fd7", 32'(frame_done), 32'h1);
      check_eq("edge_count7", 32'(frame_count), 32'h7);
      check_eq("edge_no_ovr", 32'(overrun_count), 32'h0);
      check_eq("edge_no_start", 32'(start_frame), 32'h0);

      // Asynchronous reset mid-frame, then a full period before the next start.
      do_reset();
      strand_enable = 4'b1111;
      strand_busy   = 4'b0001;
      start_run(30);
      strand_busy = '0;
      wait_edges(3);
      rst = 1'b1;
      #1;
      check_eq("mid_rst_active", 32'(frame_active), 32'h0);
      check_eq("mid_rst_counts", 32'({frame_count, overrun_count}), 32'h0);
      check_eq("mid_rst_outs", 32'({start_frame, frame_done, overrun}), 32'h0);
      wait_edges(1);
      rst = 1'b0;
      wait_edges(30);
      check_eq("post_rst_no_start", 32'(start_frame), 32'h0);
      wait_edges(1);
      check_eq("post_rst_start", 32'(start_frame), 32'hf);

      // Enable dropped during RUN: frame finishes, then no further starts.
      do_reset();
      start_run(30);
      wait_edges(2);
      enable      = 1'b0;
      strand_done = 4'b1111;
      wait_edges(1);
      strand_done = '0;
      check_eq("drop_fd", 32'(frame_done), 32'h1);
      check_eq("drop_count", 32'(frame_count), 32'h1);
      starts = 0;
      for (int i = 0; i < 100; i++) begin
         wait_edges(1);
         if (start_frame != '0 || frame_active) starts++;
      end
      check_eq("drop_no_starts", 32'(starts), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/strand_scheduler.md
STRAND_SCHEDULER -- requirements
Module: strand_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_STRANDS, default 4, meaning the number of strand_driver instances it sequences.
REQ-002 The block SHALL have parameter PERIOD_WIDTH, default 24, meaning the width of the frame period in clk cycles.
REQ-003 The block SHALL have parameter COUNT_WIDTH, default 16, meaning the width of the frame and overrun counters.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port enable, input, 1 bit: run periodic frames while high.
REQ-007 The block SHALL have port frame_period, input, PERIOD_WIDTH bits: clk cycles from one frame start to the next.
REQ-008 The block SHALL have port strand_enable, input, NUM_STRANDS bits: per-strand participation mask.
REQ-009 The block SHALL have port strand_busy, input, NUM_STRANDS bits: the busy output of each strand_driver.
REQ-010 The block SHALL have port strand_done, input, NUM_STRANDS bits: the done pulse of each strand_driver.
REQ-011 The block SHALL have port start_frame, output, NUM_STRANDS bits: one-cycle start pulse to each strand_driver.
REQ-012 The block SHALL have port frame_active, output, 1 bit: high from frame start until all launched strands report done.
REQ-013 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse when a frame completes.
REQ-014 The block SHALL have port overrun, output, 1 bit: one-cycle pulse when a period tick hits an unfinished frame or a busy strand.
REQ-015 The block SHALL have port frame_count, output, COUNT_WIDTH bits: number of completed frames.
REQ-016 The block SHALL have port overrun_count, output, COUNT_WIDTH bits: number of overrun events.

Function
REQ-017 The state machine SHALL have states IDLE, WAIT_TICK, START and RUN.
REQ-018 IDLE SHALL go to WAIT_TICK when enable=1; WAIT_TICK SHALL go to START on a period tick; START SHALL go to RUN after exactly one cycle; RUN SHALL go to WAIT_TICK when the pending mask reaches zero.
REQ-019 The period counter SHALL:
  - load 0 on leaving IDLE and count every cycle;
  - tick when count = max(frame_period,2)-1, then return to 0;
  - sample frame_period at each reload.
REQ-020 The first tick SHALL occur max(frame_period,2) cycles after enable rises.
REQ-021 In START the block SHALL:
  - pulse start_frame[i] for exactly one cycle for each i with strand_enable[i]=1 and strand_busy[i]=0;
  - load the pending mask with that same set.
REQ-022 If in START an enabled strand is busy, that strand SHALL be skipped for this frame and overrun SHALL pulse.
REQ-023 In RUN, strand_done[i] SHALL clear pending[i]; simultaneous dones SHALL all be cleared in the same cycle; a done for a non-pending strand SHALL be ignored.
REQ-024 frame_done SHALL pulse in the cycle after pending becomes zero, and frame_count SHALL increment in that same cycle, wrapping modulo 2^COUNT_WIDTH.
REQ-025 An empty launch set in START SHALL give frame_done two cycles after the tick.
REQ-026 A tick while in RUN SHALL:
  - pulse overrun and increment overrun_count (wrapping);
  - launch no new frame;
  - leave the current frame running.
REQ-027 If overrun causes from REQ-022 and REQ-026 coincide, overrun_count SHALL increment by 1 only.
REQ-028 frame_active SHALL be 1 in START and RUN and 0 otherwise.
REQ-029 Deasserting enable SHALL:
  - in WAIT_TICK, go to IDLE next cycle;
  - in START or RUN, let the current frame finish, then go to IDLE instead of WAIT_TICK.
REQ-030 Changes to strand_enable during RUN SHALL take effect only at the next START.

Reset
REQ-031 Asserting rst SHALL immediately force:
  - state IDLE;
  - period counter 0 and pending mask 0;
  - start_frame 0, frame_active 0, frame_done 0, overrun 0;
  - frame_count 0, overrun_count 0.
REQ-032 A reset in the middle of a frame SHALL abandon that frame; after rst falls, no start_frame SHALL issue until a full period elapses with enable=1.

Structure
REQ-033 The state encoding and default parameter constants SHALL live in a shared package, hydra_pkg.
REQ-034 The period counter and tick generation SHALL be a sub-module, strand_frame_timer, with ports clk, rst, run, period and tick.

Verification
REQ-035 Single frame: NUM_STRANDS=4, period=1000, strand_enable=4'b1111, all done 300 cycles after start -> one start_frame pulse of 4'b1111 at cycle 1000; frame_done at cycle 1301; frame_count=1.
REQ-036 Staggered and simultaneous dones: dones on strands 0 and 2 in the same cycle, then strand 1, then strand 3 -> frame_done exactly one cycle after strand 3's done.
REQ-037 Overrun: period=200, strand 1 never signals done -> at cycle 400: overrun pulse, overrun_count=1, no start_frame, frame_active stays 1.
REQ-038 Busy skip: strand_busy=4'b0100 at START -> start_frame=4'b1011, overrun pulses once, frame completes without strand 2.
REQ-039 Edge periods: period=0 -> ticks every 2 cycles; strand_enable=0 -> frame_done 2 cycles after each tick.
REQ-040 Reset and enable: rst asserted during RUN -> all outputs 0 immediately; enable dropped during RUN -> frame completes, then IDLE with no further starts.
